// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI responder.
package spi_pkg;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned DW_DEFAULT  = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/spi_sync.sv
// N-stage flop synchronizer with a configurable reset level.
module spi_sync #(
    parameter int unsigned N       = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= {N{RST_VAL}};
        end else begin
            sr_q <= {sr_q[N-2:0], d};
        end
    end

    assign q = sr_q[N-1];

endmodule

// File: rtl/spi_resp.sv
// Full-duplex SPI responder, all four CPOL/CPHA modes, one-word TX holding buffer.
// Define SPI_RESP_STATUS_EN to build the sticky err flag (underrun / frame abort).
module spi_resp
    import spi_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    mode,
    input  logic          sclk,
    input  logic          cs,
    input  logic          mosi,
    output logic          miso,
    input  logic [DW-1:0] tx_dat,
    input  logic          tx_valid,
    output logic          tx_ready,
    output logic [DW-1:0] rx_dat,
    output logic          rx_valid,
    output logic          err
);

    localparam int unsigned CW = $clog2(DW + 1);

    logic sclk_s, cs_s, mosi_s;

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(cs),   .q(cs_s));
    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s));

    // Edge-detect flops and registered edge strobes
    logic sclk_p_q, cs_p_q;
    logic sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_p_q    <= 1'b0;
            cs_p_q      <= 1'b1;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
        end else begin
            sclk_p_q    <= sclk_s;
            cs_p_q      <= cs_s;
            sclk_rise_q <= sclk_s & ~sclk_p_q;
            sclk_fall_q <= ~sclk_s & sclk_p_q;
            cs_rise_q   <= cs_s & ~cs_p_q;
            cs_fall_q   <= ~cs_s & cs_p_q;
        end
    end

    state_e        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [1:0]    warm_q, warm_d;
    logic          armed_q, armed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rx_sr_q, rx_sr_d;
    logic [DW-1:0] tx_sr_q, tx_sr_d;
    logic [DW-1:0] rx_dat_q, rx_dat_d;
    logic          rx_valid_q, rx_valid_d;
    logic [DW-1:0] buf_q, buf_d;
    logic          buf_empty_q, buf_empty_d;
    logic          lead_c, trail_c, sample_c, shift_c, load_c;

    // A cs fall only opens a frame once cs has genuinely been seen high after reset
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        warm_d      = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        armed_d     = armed_q | ((warm_q == 2'd3) & cs_s & cs_p_q);
        cnt_d       = cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        rx_dat_d    = rx_dat_q;
        rx_valid_d  = 1'b0;
        buf_d       = buf_q;
        buf_empty_d = buf_empty_q;
        load_c      = 1'b0;

        lead_c   = mode_q[1] ? sclk_fall_q : sclk_rise_q;
        trail_c  = mode_q[1] ? sclk_rise_q : sclk_fall_q;
        sample_c = mode_q[0] ? trail_c : lead_c;
        shift_c  = mode_q[0] ? lead_c  : trail_c;

        case (state_q)
            IDLE: begin
                if (cs_fall_q && armed_q) begin
                    state_d = ACTIVE;
                    mode_d  = mode;
                    cnt_d   = '0;
                    rx_sr_d = '0;
                    load_c  = ~mode[0];
                end
            end
            ACTIVE: begin
                if (cs_rise_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rx_sr_d = '0;
                    tx_sr_d = '0;
                end else begin
                    if (sample_c) begin
                        rx_sr_d = {rx_sr_q[DW-2:0], mosi_s};
                        if (cnt_q == CW'(DW - 1)) begin
                            cnt_d      = '0;
                            rx_dat_d   = {rx_sr_q[DW-2:0], mosi_s};
                            rx_valid_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    // Shift edge at bit count 0 is the word boundary in both cpha settings
                    if (shift_c) begin
                        if (cnt_q == '0) begin
                            load_c = 1'b1;
                        end else begin
                            tx_sr_d = {tx_sr_q[DW-2:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_c) begin
            tx_sr_d     = buf_empty_q ? '0 : buf_q;
            buf_empty_d = 1'b1;
        end
        if (tx_valid && buf_empty_q) begin
            buf_d       = tx_dat;
            buf_empty_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mode_q      <= MODE0;
            warm_q      <= 2'd0;
            armed_q     <= 1'b0;
            cnt_q       <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            rx_dat_q    <= '0;
            rx_valid_q  <= 1'b0;
            buf_q       <= '0;
            buf_empty_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            warm_q      <= warm_d;
            armed_q     <= armed_d;
            cnt_q       <= cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            rx_dat_q    <= rx_dat_d;
            rx_valid_q  <= rx_valid_d;
            buf_q       <= buf_d;
            buf_empty_q <= buf_empty_d;
        end
    end

    assign miso     = tx_sr_q[DW-1];
    assign tx_ready = buf_empty_q;
    assign rx_dat   = rx_dat_q;
    assign rx_valid = rx_valid_q;

`ifdef SPI_RESP_STATUS_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((load_c && buf_empty_q) ||
                     (state_q == ACTIVE && cs_rise_q && cnt_q != '0)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
